// File: rtl/rtype_issue_ctrl_pkg.sv
// Shared constants, FSM state type and instruction decoder for the R-type issue controller.
package rtype_issue_ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StIssue = 1'b1
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] ctl;
  } dec_t;

  // Anything outside the four supported R-type operations comes back with legal=0.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.legal = 1'b0;
    d.ctl   = ALU_AND;
    if (instr[6:0] == OPC_RTYPE) begin
      case ({instr[31:25], instr[14:12]})
        {F7_BASE, F3_ADD_SUB}: begin d.legal = 1'b1; d.ctl = ALU_ADD; end
        {F7_SUB,  F3_ADD_SUB}: begin d.legal = 1'b1; d.ctl = ALU_SUB; end
        {F7_BASE, F3_AND}:     begin d.legal = 1'b1; d.ctl = ALU_AND; end
        {F7_BASE, F3_OR}:      begin d.legal = 1'b1; d.ctl = ALU_OR;  end
        default:               d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/rtype_issue_ctrl_instr_fifo.sv
// Instruction FIFO with registered full/empty flags. Reads are combinational from the head
// entry, but since empty is registered a word written at one edge is not visible as a pop
// candidate until the next edge.
module rtype_issue_ctrl_instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic [AW:0]      w_cnt_d;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  // Full/empty gate the requests so the pointers can never over- or under-run.
  always_comb begin
    w_push  = i_push & ~r_full;
    w_pop   = i_pop & ~r_empty;
    w_cnt_d = r_cnt;
    if (w_push && !w_pop) begin
      w_cnt_d = r_cnt + (AW + 1)'(1);
    end else if (!w_push && w_pop) begin
      w_cnt_d = r_cnt - (AW + 1)'(1);
    end
  end

  // Pointers, occupancy and the registered flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_cnt   <= w_cnt_d;
      r_full  <= (w_cnt_d == FULL_CNT);
      r_empty <= (w_cnt_d == '0);
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/rtype_issue_ctrl.sv
// Issue controller: buffers R-type words, decodes them and drives a one-cycle command to the
// regfile+ALU datapath per instruction, tracking retire count, zero flag and illegal status.
module rtype_issue_ctrl
  import rtype_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             stall,
  input  logic             zero,
  output logic [4:0]       rr1,
  output logic [4:0]       rr2,
  output logic [4:0]       wr,
  output logic             rw,
  output logic [3:0]       ctl,
  output logic             last_zero,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [31:0]      w_fifo_rdata;
  logic             w_pop;
  dec_t             w_dec;
  state_e           r_state;
  state_e           w_state_d;
  logic [4:0]       r_rr1;
  logic [4:0]       r_rr2;
  logic [4:0]       r_wr;
  logic             r_rw;
  logic [3:0]       r_ctl;
  logic             r_cur_legal;
  logic             r_last_zero;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  assign w_pop = ~w_fifo_empty & ~stall;

  rtype_issue_ctrl_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_instr_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_wdata (in_instr),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_dec = decode(w_fifo_rdata);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_d;
  end

  // Next state: every pop starts (or continues) an issue cycle.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_pop) w_state_d = StIssue;
      StIssue: w_state_d = w_pop ? StIssue : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // FSM-derived status outputs.
  always_comb begin
    busy     = ~w_fifo_empty | (r_state == StIssue);
    in_ready = ~w_fifo_full;
  end

  // Command registers, loaded on the pop edge so they are valid during the issue cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr1       <= '0;
      r_rr2       <= '0;
      r_wr        <= '0;
      r_rw        <= 1'b0;
      r_ctl       <= '0;
      r_cur_legal <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_rw        <= 1'b0;
      r_cur_legal <= 1'b0;
      if (w_pop) begin
        if (w_dec.legal) begin
          r_rr1       <= w_fifo_rdata[19:15];
          r_rr2       <= w_fifo_rdata[24:20];
          r_wr        <= w_fifo_rdata[11:7];
          r_ctl       <= w_dec.ctl;
          r_rw        <= (w_fifo_rdata[11:7] != 5'd0);
          r_cur_legal <= 1'b1;
        end else begin
          // Dropped word leaves the previous command fields untouched.
          r_illegal <= 1'b1;
        end
      end
    end
  end

  // Retire bookkeeping at the end of a legal issue cycle, when zero is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_zero <= 1'b0;
      r_retired   <= '0;
    end else if ((r_state == StIssue) && r_cur_legal) begin
      r_last_zero <= zero;
      r_retired   <= r_retired + CNT_W'(1);
    end
  end

  assign rr1           = r_rr1;
  assign rr2           = r_rr2;
  assign wr            = r_wr;
  assign rw            = r_rw;
  assign ctl           = r_ctl;
  assign last_zero     = r_last_zero;
  assign illegal       = r_illegal;
  assign retired_count = r_retired;

endmodule
